riscv_v_vsetvl_unit: RTL and testbench
======================================

Name: riscv_v_vsetvl_unit

Overview:
Executes the vector configuration instructions vsetvli, vsetivli and vsetvl, which set the vector length and element type. It computes the new vtype and vl values and writes them into the vector CSR block using one-cycle write-enable pulses. It also clears vstart and returns the new vl to the scalar writeback path. It sits directly upstream of the vector CSR and is fed by the vector decode/issue stage through a valid/ready handshake.

Parameters:
XLEN, 32, scalar register width; vtype and rd are both XLEN wide.
VLEN, 128, vector register width in bits.
ELEN, 32, maximum supported SEW in bits.
VL_W, $clog2(VLEN/8)+1, width of vl (holds 0..VLEN/8).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  instruction valid from issue
req_ready  out  1  unit can accept an instruction
req_op  in  2  0=vsetvli, 1=vsetivli, 2=vsetvl, 3=reserved (treated as vill)
req_rs1_val  in  XLEN  AVL source (op 0/2)
req_rs1_is_x0  in  1  rs1 field is x0
req_rd_is_x0  in  1  rd field is x0
req_uimm  in  5  AVL immediate (op 1)
req_zimm  in  11  vtype immediate (op 0/1)
req_rs2_val  in  XLEN  vtype source (op 2)
cur_vl_in  in  VL_W  current vl read from the CSR block
vtype_data_out  out  XLEN  new vtype
vtype_wr_en  out  1  vtype write pulse
vl_data_out  out  VL_W  new vl
vl_wr_en  out  1  vl write pulse
vstart_data_out  out  XLEN  always 0
vstart_wr_en  out  1  vstart write pulse
resp_valid  out  1  rd result valid
resp_ready  in  1  writeback accepts the result
resp_rd_val  out  XLEN  new vl, zero-extended
resp_rd_wr_en  out  1  rd must be written (rd != x0)
busy  out  1  state != IDLE

Behaviour:
- Clock, reset and handshakes:
  - One clock: clk. Reset rst_n is synchronous and active-low.
  - Request handshake occurs on req_valid & req_ready. Response handshake occurs on resp_valid & resp_ready.
- FSM states: IDLE -> CALC -> COMMIT -> RESP -> IDLE.
  - IDLE: req_ready=1. On request handshake, latch all req_* fields and go to CALC.
  - CALC: one cycle. Compute the new vtype and vl and register them.
  - COMMIT: one cycle. Assert vtype_wr_en, vl_wr_en and vstart_wr_en together, each exactly one cycle.
  - RESP: resp_valid=1. resp_rd_val and resp_rd_wr_en hold stable until the response handshake, then go to IDLE.
- Latency: accept in cycle N, write-enable pulse in N+2, resp_valid from N+3. Minimum issue interval is 4 cycles.
- vtype source and layout:
  - Source is the zero-extended zimm for op 0/1, and rs2 for op 2.
  - Bit layout: vill=[XLEN-1], vma=[7], vta=[6], vsew=[5:3], vlmul=[2:0].
- vill is set if any of the following hold:
  - any bit in [XLEN-2:8] is nonzero;
  - vsew>3;
  - (8<<vsew) > ELEN;
  - vlmul != 0 (only LMUL=1 is supported);
  - req_op == 3.
- When vill is set: vtype_data_out = 1<<(XLEN-1) with all other bits 0, vl=0, rd=0.
- VLMAX = VLEN >> (3+vsew).
- AVL selection:
  - op 1: AVL = req_uimm.
  - rs1 != x0: AVL = req_rs1_val (full XLEN compare).
  - rs1 == x0 and rd != x0: AVL = all-ones, so vl=VLMAX.
  - rs1 == x0 and rd == x0: vl = cur_vl_in, sampled in CALC. If cur_vl_in > VLMAX, vill is set instead.
- vl = min(AVL, VLMAX). resp_rd_val = {0, vl}. resp_rd_wr_en = !rd_is_x0.
- Reset values: req_ready=1 (when rst_n=1), all *_wr_en=0, resp_valid=0, resp_rd_wr_en=0, busy=0, data outputs 0.
- Reset asserted in any state returns the FSM to IDLE on that edge. A transaction interrupted before COMMIT writes nothing. A request presented while the unit is not ready is ignored, not queued.
- Boundary conditions:
  - AVL=0 gives vl=0 with a legal vtype.
  - AVL >= 2^(XLEN-1) is treated as unsigned.
  - resp_ready held low stalls in RESP indefinitely, with no additional write pulses.

Test Plan:
1. vsetvli, rs1_val=10, zimm=0x010 (SEW32) -> vtype=0x00000010, vl=4, rd=4, wr_en pulse at N+2, resp_valid at N+3.
2. vsetivli, uimm=3, zimm=0x0C0 (vta=1, vma=1, SEW8) -> vtype=0x000000C0, vl=3, rd=3.
3. vsetvl, rs2=0x00000018 (SEW64 > ELEN) -> vtype=0x80000000, vl=0, rd=0; rs2=0x00000001 (LMUL2) -> same result; rs2=0x00000100 (reserved bit 8) -> same result.
4. vsetvli, rs1=x0, rd!=x0, zimm=0x008 -> vl=8, rd=8, resp_rd_wr_en=1. rs1=x0, rd=x0, cur_vl_in=6, SEW32 -> vill (6 > 4), resp_rd_wr_en=0.
5. Backpressure: resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0, a second req_valid is ignored, exactly one write pulse per instruction.
6. rst_n=0 during CALC -> no wr_en pulses, resp_valid=0, busy=0, req_ready=1 on the first cycle after reset releases.

Source files
------------

// File: rtl/riscv_v_vsetvl_unit_if.sv
// Issue/CSR/writeback bundle for the vsetvl unit.
// The master side is the issue stage plus the CSR block and writeback. The slave side is the unit.
interface riscv_v_vsetvl_unit_if #(
  parameter int XLEN = 32,
  parameter int VL_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_rs1_val;
  logic            req_rs1_is_x0;
  logic            req_rd_is_x0;
  logic [4:0]      req_uimm;
  logic [10:0]     req_zimm;
  logic [XLEN-1:0] req_rs2_val;
  logic [VL_W-1:0] cur_vl_in;
  logic [XLEN-1:0] vtype_data_out;
  logic            vtype_wr_en;
  logic [VL_W-1:0] vl_data_out;
  logic            vl_wr_en;
  logic [XLEN-1:0] vstart_data_out;
  logic            vstart_wr_en;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rd_val;
  logic            resp_rd_wr_en;
  logic            busy;

  modport master (
    output req_valid, req_op, req_rs1_val, req_rs1_is_x0, req_rd_is_x0,
           req_uimm, req_zimm, req_rs2_val, cur_vl_in, resp_ready,
    input  req_ready, vtype_data_out, vtype_wr_en, vl_data_out, vl_wr_en,
           vstart_data_out, vstart_wr_en, resp_valid, resp_rd_val,
           resp_rd_wr_en, busy
  );

  modport slave (
    input  req_valid, req_op, req_rs1_val, req_rs1_is_x0, req_rd_is_x0,
           req_uimm, req_zimm, req_rs2_val, cur_vl_in, resp_ready,
    output req_ready, vtype_data_out, vtype_wr_en, vl_data_out, vl_wr_en,
           vstart_data_out, vstart_wr_en, resp_valid, resp_rd_val,
           resp_rd_wr_en, busy
  );
endinterface

// File: rtl/riscv_v_vsetvl_unit.sv
// vsetvli / vsetivli / vsetvl execution.
// The FSM moves through IDLE -> CALC -> COMMIT -> RESP. It sends one CSR write pulse and then holds the rd result.
module riscv_v_vsetvl_unit #(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int VL_W = $clog2(VLEN/8) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_v_vsetvl_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, COMMIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            rs1_x0_q, rs1_x0_d;
  logic            rd_x0_q, rd_x0_d;
  logic [4:0]      uimm_q, uimm_d;
  logic [10:0]     zimm_q, zimm_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] vtype_q, vtype_d;
  logic [VL_W-1:0] vl_q, vl_d;

  logic [XLEN-1:0] src, vlmax, avl, vl_full, cur_vl_ext;
  logic [2:0]      vsew, vlmul;
  logic            vill;

  // vtype legality, VLMAX and AVL selection from the latched request
  always_comb begin
    src        = (op_q == 2'd2) ? rs2_q : {{(XLEN-11){1'b0}}, zimm_q};
    vsew       = src[5:3];
    vlmul      = src[2:0];
    vlmax      = XLEN'(VLEN >> (3 + int'(vsew)));
    cur_vl_ext = {{(XLEN-VL_W){1'b0}}, bus.cur_vl_in};
    vill       = (|src[XLEN-2:8]) || (vsew > 3'd3) || ((32'd8 << vsew) > ELEN)
                 || (vlmul != 3'd0) || (op_q == 2'd3);
    if (op_q == 2'd1)   avl = {{(XLEN-5){1'b0}}, uimm_q};
    else if (!rs1_x0_q) avl = rs1_q;
    else if (!rd_x0_q)  avl = '1;
    else begin
      // Keep the current vl. It is illegal if the new SEW cannot hold it.
      avl = cur_vl_ext;
      if (cur_vl_ext > vlmax) vill = 1'b1;
    end
    vl_full = (avl < vlmax) ? avl : vlmax;
  end

  // Next-state logic and request/result latching
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs1_x0_d = rs1_x0_q;
    rd_x0_d  = rd_x0_q;
    uimm_d   = uimm_q;
    zimm_d   = zimm_q;
    rs2_d    = rs2_q;
    vtype_d  = vtype_q;
    vl_d     = vl_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d     = bus.req_op;
        rs1_d    = bus.req_rs1_val;
        rs1_x0_d = bus.req_rs1_is_x0;
        rd_x0_d  = bus.req_rd_is_x0;
        uimm_d   = bus.req_uimm;
        zimm_d   = bus.req_zimm;
        rs2_d    = bus.req_rs2_val;
        state_d  = CALC;
      end
      CALC: begin
        vtype_d = vill ? {1'b1, {(XLEN-1){1'b0}}} : src;
        vl_d    = vill ? '0 : vl_full[VL_W-1:0];
        state_d = COMMIT;
      end
      COMMIT: state_d = RESP;
      RESP:   if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs1_x0_q <= 1'b0;
      rd_x0_q  <= 1'b0;
      uimm_q   <= '0;
      zimm_q   <= '0;
      rs2_q    <= '0;
      vtype_q  <= '0;
      vl_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs1_x0_q <= rs1_x0_d;
      rd_x0_q  <= rd_x0_d;
      uimm_q   <= uimm_d;
      zimm_q   <= zimm_d;
      rs2_q    <= rs2_d;
      vtype_q  <= vtype_d;
      vl_q     <= vl_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.vtype_data_out  = vtype_q;
  assign bus.vl_data_out     = vl_q;
  assign bus.vstart_data_out = '0;
  assign bus.vtype_wr_en     = (state_q == COMMIT);
  assign bus.vl_wr_en        = (state_q == COMMIT);
  assign bus.vstart_wr_en    = (state_q == COMMIT);
  assign bus.resp_valid      = (state_q == RESP);
  assign bus.resp_rd_val     = {{(XLEN-VL_W){1'b0}}, vl_q};
  assign bus.resp_rd_wr_en   = (state_q == RESP) && !rd_x0_q;
endmodule

// File: tb/tb_riscv_v_vsetvl_unit.sv
// Scoreboard bench for riscv_v_vsetvl_unit (XLEN=32, VLEN=128, ELEN=32).
module tb_riscv_v_vsetvl_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_rv = 1'b0;

  typedef struct { logic [31:0] vtype; logic [4:0] vl; int cyc; } wr_t;
  typedef struct { logic [31:0] rd; logic we; int cyc; } rsp_t;
  wr_t  wr_q[$];
  rsp_t rsp_q[$];

  riscv_v_vsetvl_unit_if #(.XLEN(32), .VL_W(5)) bus();
  riscv_v_vsetvl_unit #(.XLEN(32), .VLEN(128), .ELEN(32), .VL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: pops expectations as write pulses and responses appear
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vtype_wr_en || bus.vl_wr_en || bus.vstart_wr_en) begin
        checks++;
        if (!(bus.vtype_wr_en && bus.vl_wr_en && bus.vstart_wr_en)) begin
          errors++;
          $display("FAIL wr_en_sync got %b%b%b want 111", bus.vtype_wr_en, bus.vl_wr_en, bus.vstart_wr_en);
        end
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr_pulse at cycle %0d", cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (bus.vtype_data_out !== w.vtype || bus.vl_data_out !== w.vl ||
              bus.vstart_data_out !== 32'd0 || cyc != w.cyc) begin
            errors++;
            $display("FAIL csr_write got vtype=%h vl=%0d vstart=%h cyc=%0d want vtype=%h vl=%0d vstart=0 cyc=%0d",
                     bus.vtype_data_out, bus.vl_data_out, bus.vstart_data_out, cyc, w.vtype, w.vl, w.cyc);
          end
        end
      end
      if (bus.resp_valid) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp at cycle %0d", cyc);
        end else begin
          rsp_t r;
          r = rsp_q[0];
          if (!prev_rv && cyc != r.cyc) begin
            errors++;
            $display("FAIL resp_latency got cyc=%0d want cyc=%0d", cyc, r.cyc);
          end
          if (bus.resp_rd_val !== r.rd || bus.resp_rd_wr_en !== r.we) begin
            errors++;
            $display("FAIL resp_data got rd=%h we=%b want rd=%h we=%b",
                     bus.resp_rd_val, bus.resp_rd_wr_en, r.rd, r.we);
          end
          if (bus.resp_ready) void'(rsp_q.pop_front());
        end
      end
    end
    prev_rv = bus.resp_valid;
  end

  task automatic send(input logic [1:0] op, input logic [31:0] rs1, input logic rs1x0,
                      input logic rdx0, input logic [4:0] uimm, input logic [10:0] zimm,
                      input logic [31:0] rs2, input logic [4:0] cvl,
                      input logic [31:0] ev, input logic [4:0] evl, input logic ewe);
    int n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout req_ready=%b want 1", bus.req_ready);
    end else begin
      bus.req_op = op; bus.req_rs1_val = rs1; bus.req_rs1_is_x0 = rs1x0;
      bus.req_rd_is_x0 = rdx0; bus.req_uimm = uimm; bus.req_zimm = zimm;
      bus.req_rs2_val = rs2; bus.cur_vl_in = cvl; bus.req_valid = 1'b1;
      wr_q.push_back('{ev, evl, cyc + 2});
      rsp_q.push_back('{{27'd0, evl}, ewe, cyc + 3});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || rsp_q.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (wr_q.size() != 0 || rsp_q.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL drain_timeout got wr_pending=%0d rsp_pending=%0d busy=%b want 0 0 0",
               wr_q.size(), rsp_q.size(), bus.busy);
      wr_q.delete(); rsp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1; bus.req_op = '0;
    bus.req_rs1_val = '0; bus.req_rs1_is_x0 = 1'b0; bus.req_rd_is_x0 = 1'b0;
    bus.req_uimm = '0; bus.req_zimm = '0; bus.req_rs2_val = '0; bus.cur_vl_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_rd_wr_en !== 1'b0 || bus.vtype_wr_en !== 1'b0 || bus.vl_wr_en !== 1'b0 ||
        bus.vstart_wr_en !== 1'b0 || bus.vtype_data_out !== 32'd0 || bus.vl_data_out !== 5'd0 ||
        bus.resp_rd_val !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got ready=%b busy=%b rv=%b we=%b wr=%b%b%b vtype=%h vl=%0d rd=%h want 1 0 0 0 000 0 0 0",
               bus.req_ready, bus.busy, bus.resp_valid, bus.resp_rd_wr_en, bus.vtype_wr_en,
               bus.vl_wr_en, bus.vstart_wr_en, bus.vtype_data_out, bus.vl_data_out, bus.resp_rd_val);
    end
  endtask

  task automatic test_vsetvli();
    send(2'd0, 32'd10, 1'b0, 1'b0, 5'd0, 11'h010, 32'd0, 5'd0, 32'h10, 5'd4, 1'b1);
    drain();
  endtask

  task automatic test_vsetivli();
    send(2'd1, 32'd0, 1'b1, 1'b0, 5'd3, 11'h0C0, 32'd0, 5'd0, 32'hC0, 5'd3, 1'b1);
    drain();
  endtask

  task automatic test_vsetvl_vill();
    send(2'd2, 32'd10, 1'b0, 1'b0, 5'd0, 11'h0, 32'h18,  5'd0, 32'h8000_0000, 5'd0, 1'b1);
    send(2'd2, 32'd10, 1'b0, 1'b0, 5'd0, 11'h0, 32'h01,  5'd0, 32'h8000_0000, 5'd0, 1'b1);
    send(2'd2, 32'd10, 1'b0, 1'b0, 5'd0, 11'h0, 32'h100, 5'd0, 32'h8000_0000, 5'd0, 1'b1);
    send(2'd3, 32'd10, 1'b0, 1'b0, 5'd0, 11'h0, 32'h0,   5'd0, 32'h8000_0000, 5'd0, 1'b1);
    send(2'd2, 32'd7,  1'b0, 1'b0, 5'd0, 11'h0, 32'h10,  5'd0, 32'h10, 5'd4, 1'b1);
    drain();
  endtask

  task automatic test_x0_forms();
    send(2'd0, 32'd99, 1'b1, 1'b0, 5'd0, 11'h008, 32'd0, 5'd0, 32'h08, 5'd8, 1'b1);
    send(2'd0, 32'd99, 1'b1, 1'b1, 5'd0, 11'h010, 32'd0, 5'd6, 32'h8000_0000, 5'd0, 1'b0);
    send(2'd0, 32'd99, 1'b1, 1'b1, 5'd0, 11'h010, 32'd0, 5'd3, 32'h10, 5'd3, 1'b0);
    drain();
  endtask

  task automatic test_boundary();
    send(2'd0, 32'd0,          1'b0, 1'b0, 5'd0, 11'h000, 32'd0, 5'd0, 32'h00, 5'd0,  1'b1);
    send(2'd0, 32'h8000_0000, 1'b0, 1'b0, 5'd0, 11'h000, 32'd0, 5'd0, 32'h00, 5'd16, 1'b1);
    send(2'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 11'h008, 32'd0, 5'd0, 32'h08, 5'd8,  1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [4:0] u;
      u = 5'(i * 3);
      send(2'd1, 32'd0, 1'b0, 1'b0, u, 11'h000, 32'd0, 5'd0, 32'h00, (u > 5'd16) ? 5'd16 : u, 1'b1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n = 0;
    bus.resp_ready = 1'b0;
    send(2'd0, 32'd10, 1'b0, 1'b0, 5'd0, 11'h010, 32'd0, 5'd0, 32'h10, 5'd4, 1'b1);
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.resp_valid) begin
      errors++;
      $display("FAIL bp_resp_timeout resp_valid=%b want 1", bus.resp_valid);
    end
    @(posedge clk); #1;
    bus.req_op = 2'd1; bus.req_uimm = 5'd7; bus.req_zimm = 11'h0; bus.req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.busy !== 1'b1 ||
          bus.resp_rd_val !== 32'd4) begin
        errors++;
        $display("FAIL bp_stall got ready=%b rv=%b busy=%b rd=%h want 0 1 1 00000004",
                 bus.req_ready, bus.resp_valid, bus.busy, bus.resp_rd_val);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    bus.req_op = 2'd0; bus.req_rs1_val = 32'd5; bus.req_rs1_is_x0 = 1'b0;
    bus.req_rd_is_x0 = 1'b0; bus.req_zimm = 11'h010; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.vtype_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b ready=%b rv=%b wr=%b want 0 1 0 0",
               bus.busy, bus.req_ready, bus.resp_valid, bus.vtype_wr_en);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.vtype_wr_en || bus.vl_wr_en || bus.vstart_wr_en || bus.resp_valid) begin
        errors++;
        $display("FAIL reset_mid_quiet got wr=%b%b%b rv=%b want 0000",
                 bus.vtype_wr_en, bus.vl_wr_en, bus.vstart_wr_en, bus.resp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vsetvli();
    test_vsetivli();
    test_vsetvl_vill();
    test_x0_forms();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    send(2'd1, 32'd0, 1'b0, 1'b0, 5'd2, 11'h0D0, 32'd0, 5'd0, 32'hD0, 5'd2, 1'b1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
